// File: rtl/score_display_n.sv
// Score overlay: iterative double-dabble BCD conversion, frame-synchronous commit,
// and an 8x8 digit-font renderer with integer scaling and leading-zero blanking.

module score_dd_nib (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

module score_display_n #(
  parameter int NDIGITS    = 4,
  parameter int BIN_W      = 14,
  parameter int SCALE_LOG2 = 0,
  parameter int XSTART     = 20,
  parameter int YSTART     = 20,
  parameter int XALT       = 300,
  parameter int YALT       = 340
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pixpulse,
  input  logic [1:0]             state_set,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  input  logic [BIN_W-1:0]       score,
  input  logic                   lz_blank,
  output logic                   draw_score,
  output logic                   busy,
  output logic [4*NDIGITS-1:0]   bcd_value
);
  localparam int NNIB  = NDIGITS + 1;
  localparam int AW    = 4 * NNIB;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int CW    = (BIN_W > 32) ? BIN_W : 32;
  localparam logic [CW-1:0] MAXV = CW'(10**NDIGITS - 1);
  localparam int BOX_W = (8 * NDIGITS) << SCALE_LOG2;
  localparam int BOX_H = 8 << SCALE_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} st_t;

  st_t                        st_q, st_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [BIN_W-1:0]           shreg_q, shreg_d;
  logic [NNIB-1:0][3:0]       acc_q, acc_d, acc_adj;
  logic [BIN_W-1:0]           lat_q, lat_d;
  logic [BIN_W-1:0]           last_q, last_d;
  logic                       busy_q, busy_d;
  logic [4*NDIGITS-1:0]       pend_q, pend_d;
  logic                       pv_q, pv_d;
  logic [4*NDIGITS-1:0]       bcd_q, bcd_d;
  logic [9:0]                 x0_q, x0_d, y0_q, y0_d;
  logic                       draw_q, draw_d;

  logic [AW+BIN_W-1:0]        sh_w;
  logic [4*NDIGITS-1:0]       res;
  logic                       sat, done, frame;

  // Per-nibble +3 correction lanes ahead of the shift
  for (genvar i = 0; i < NNIB; i++) begin : g_dd
    score_dd_nib u_nib (.nib_i(acc_q[i]), .nib_o(acc_adj[i]));
  end

  assign sh_w  = {acc_adj, shreg_q} << 1;
  assign sat   = CW'(lat_q) > MAXV;
  assign res   = sat ? {NDIGITS{4'h9}} : acc_q[NDIGITS-1:0];
  assign frame = pixpulse && (hcount == 10'd0) && (vcount == 10'd0);

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    lat_d   = lat_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done    = 1'b0;
    case (st_q)
      S_IDLE: if (score != last_q) begin
        lat_d   = score;
        shreg_d = score;
        acc_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        st_d    = S_SHIFT;
      end
      S_SHIFT: begin
        acc_d   = sh_w[AW+BIN_W-1 -: AW];
        shreg_d = sh_w[BIN_W-1:0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) st_d = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        last_d = lat_q;
        busy_d = 1'b0;
        st_d   = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  // A result finishing on the frame-start pulse goes straight to the display
  always_comb begin
    pend_d = pend_q;
    pv_d   = pv_q;
    bcd_d  = bcd_q;
    x0_d   = x0_q;
    y0_d   = y0_q;
    if (done) begin
      pend_d = res;
      pv_d   = 1'b1;
    end
    if (frame) begin
      if (done) begin
        bcd_d = res;
        pv_d  = 1'b0;
      end else if (pv_q) begin
        bcd_d = pend_q;
        pv_d  = 1'b0;
      end
      x0_d = (state_set == 2'b10) ? 10'(XALT) : 10'(XSTART);
      y0_d = (state_set == 2'b10) ? 10'(YALT) : 10'(YSTART);
    end
  end

  function automatic logic [7:0] font_row(input logic [3:0] n, input logic [2:0] r);
    logic [63:0] g;
    logic [5:0]  base;
    case (n)
      4'd0: g = 64'h003C666E76663C00;
      4'd1: g = 64'h0018381818187E00;
      4'd2: g = 64'h003C66061C307E00;
      4'd3: g = 64'h003C660C06663C00;
      4'd4: g = 64'h000C1C3C6C7E0C00;
      4'd5: g = 64'h007E607C06663C00;
      4'd6: g = 64'h003C607C66663C00;
      4'd7: g = 64'h007E060C18181800;
      4'd8: g = 64'h003C663C66663C00;
      4'd9: g = 64'h003C663E060C3800;
      default: g = 64'h0;
    endcase
    base = {3'd7 - r, 3'b000};
    return g[base +: 8];
  endfunction

  logic [NDIGITS-1:0][3:0] digs;
  logic [9:0]              dx, dy, dig;
  logic [2:0]              col, row;
  logic [3:0]              nib;
  logic                    zrun, in_box;
  logic [7:0]              frow;

  assign digs = bcd_q;

  always_comb begin
    dx     = hcount - x0_q;
    dy     = vcount - y0_q;
    in_box = (hcount >= x0_q) && (dx < 10'(BOX_W)) &&
             (vcount >= y0_q) && (dy < 10'(BOX_H));
    dig    = dx >> (3 + SCALE_LOG2);
    col    = dx[SCALE_LOG2 +: 3];
    row    = dy[SCALE_LOG2 +: 3];
    zrun   = 1'b1;
    nib    = 4'hF;
    // Lane 0 is the most significant digit; 4'hF renders as blank
    for (int i = 0; i < NDIGITS; i++) begin
      zrun = zrun && (digs[NDIGITS-1-i] == 4'd0);
      if (dig == 10'(i))
        nib = (lz_blank && (i < NDIGITS - 1) && zrun) ? 4'hF : digs[NDIGITS-1-i];
    end
    frow   = font_row(nib, row);
    draw_d = pixpulse ? (in_box && frow[3'd7 - col]) : draw_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      acc_q   <= '0;
      lat_q   <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      bcd_q   <= '0;
      x0_q    <= 10'(XSTART);
      y0_q    <= 10'(YSTART);
      draw_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      lat_q   <= lat_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      bcd_q   <= bcd_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      draw_q  <= draw_d;
    end
  end

  assign draw_score = draw_q;
  assign busy       = busy_q;
  assign bcd_value  = bcd_q;

endmodule
